axi4_mem_slv_responder: RTL and testbench
=========================================

// Module: axi4_mem_slv_responder
// PURPOSE
// Synthesizable AXI4 slave with an internal word memory; the RTL responder for the AXI master/passthrough VIP bench.
// Accepts write and read bursts on independent channels, one outstanding transaction per direction.
// Replaces the slave VIP as the end point behind the passthrough VIP in the chip-level example design.
// PARAMETERS
// DATA_W   32  data bus width in bits (32 or 64); AxSIZE is implied = log2(DATA_W/8)
// ADDR_W   32  address width in bits
// DEPTH    256 memory depth in DATA_W words (power of 2); valid byte range 0 .. DEPTH*DATA_W/8-1
// PORTS
// aclk           in   1         clock; all logic on rising edge
// aresetn        in   1         synchronous active-low reset
// s_axi_awaddr   in   ADDR_W    write burst start address
// s_axi_awlen    in   8         write beats minus 1
// s_axi_awburst  in   2         00 FIXED, 01 INCR, 10 WRAP
// s_axi_awvalid  in   1         AW valid
// s_axi_awready  out  1         AW ready
// s_axi_wdata    in   DATA_W    write data
// s_axi_wstrb    in   DATA_W/8  byte enables
// s_axi_wlast    in   1         last write beat
// s_axi_wvalid   in   1         W valid
// s_axi_wready   out  1         W ready
// s_axi_bresp    out  2         00 OKAY, 10 SLVERR
// s_axi_bvalid   out  1         B valid
// s_axi_bready   in   1         B ready
// s_axi_araddr   in   ADDR_W    read burst start address
// s_axi_arlen    in   8         read beats minus 1
// s_axi_arburst  in   2         as awburst
// s_axi_arvalid  in   1         AR valid
// s_axi_arready  out  1         AR ready
// s_axi_rdata    out  DATA_W    read data
// s_axi_rresp    out  2         00 OKAY, 10 SLVERR
// s_axi_rlast    out  1         last read beat
// s_axi_rvalid   out  1         R valid
// s_axi_rready   in   1         R ready
// BEHAVIOUR
// - Reset (aresetn=0 at edge): all outputs 0, both FSMs to IDLE; awready/arready rise the first cycle after release. Memory is not cleared.
// - Reset mid-burst: the burst is abandoned, beats already written are kept, and no B/R response is issued.
// - Word index = addr[log2(DATA_W/8) +: log2(DEPTH)]. Low address bits are ignored (bursts are treated as aligned).
// - Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
//   - W_IDLE: awready=1; on the AW handshake, latch addr/len/burst and zero the beat counter.
//   - W_DATA: wready=1; each W handshake writes the bytes selected by wstrb, then advances the address and counter.
//   - W_DATA exits to W_RESP on the wlast handshake; bvalid is asserted the next cycle.
//   - W_RESP: bvalid is held until bready. bresp is registered before bvalid and is stable while bvalid=1.
// - bresp = SLVERR if any of:
//   - wlast arrives on a beat index other than awlen;
//   - the beat counter exceeds awlen before wlast arrives (further beats are ignored until wlast);
//   - any beat address is out of range (that beat is suppressed);
//   - the burst is unsupported.
// - Read FSM R_IDLE -> R_DATA -> R_IDLE.
//   - On the AR handshake at cycle N, the first rvalid is at N+2 (registered memory read).
//   - With rready held high, one beat per cycle; bubble-free via a one-entry skid buffer.
//   - rdata/rresp/rlast are held stable while rvalid=1 and rready=0.
//   - rlast=1 only on beat arlen.
//   - arready=0 throughout R_DATA and rises the cycle after the rlast handshake.
// - Read of an out-of-range beat: rdata=0, rresp=SLVERR for that beat only.
// - Address update per beat:
//   - FIXED: no change.
//   - INCR: +1 word; the word index wraps modulo DEPTH. The out-of-range check uses the full address.
//   - WRAP: see CONFIGURATION.
// - Same-cycle read and write to the same word: read-first (the read returns the old data).
// - Write and read channels operate fully concurrently; there is no ordering between them.
// - Burst type 11 (reserved): SLVERR; writes suppressed; reads return 0.
// CONFIGURATION
// AXI_SLV_WRAP_EN defined: WRAP is supported.
// - Legal lengths are 1, 3, 7 or 15.
// - Wrap boundary = (len+1)*DATA_W/8 bytes; the word index wraps within the aligned block.
// - An illegal WRAP length gives SLVERR with writes suppressed.
// AXI_SLV_WRAP_EN undefined: WRAP is treated as burst type 11 (SLVERR, no write, read data 0).
// TESTING
// 1. AW 0x10 len=3 INCR, W 0xA0..0xA3 strb F -> bresp 00; AR 0x10 len=3 -> rdata A0,A1,A2,A3, rlast on beat 3, rresp 00, first rvalid 2 cycles after AR.
// 2. Write 0xFFFFFFFF strb F, then 0x12345678 strb 0x3 at 0x40 -> read 0x40 returns 0xFFFF5678.
// 3. AW at DEPTH*4 len=0 -> bresp 10, memory unchanged; AR same address len=1 -> rdata 0, rresp 10 on both beats.
// 4. Read len=7 with rready toggling 1,0,0,1... -> rdata stable while stalled, 8 beats in order, no loss or duplication.
// 5. AW len=3 but wlast on beat 1 -> bresp 10; the next burst completes OKAY.
// 6. AW 0x18 len=3 WRAP, data 1..4 -> WRAP_EN: words 0x18,0x1C,0x10,0x14 = 1,2,3,4 and bresp 00; without WRAP_EN: bresp 10 and memory unchanged.

Source files
------------

// File: rtl/axi4_mem_slv_responder_if.sv
// rtl/axi4_mem_slv_responder_if.sv - AXI4 write/read channel bundle for the memory responder
interface axi4_mem_slv_responder_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  araddr, arlen, arburst, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );

   modport master (
      output awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output araddr, arlen, arburst, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi4_mem_slv_responder.sv
// rtl/axi4_mem_slv_responder.sv - AXI4 slave with internal word memory, one burst per direction
// WRAP bursts are accepted only when AXI_SLV_WRAP_EN is defined.
module axi4_mem_slv_responder #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256
) (
   input logic                     aclk,
   input logic                     aresetn,
   axi4_mem_slv_responder_if.slave s_axi
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int WW    = ADDR_W - OFF_W;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
`ifdef AXI_SLV_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   logic [DATA_W-1:0] r_mem [DEPTH];

   function automatic logic f_unsup(input logic [1:0] burst, input logic [7:0] len);
      logic w_len_ok;
      w_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      f_unsup  = (burst == 2'b11) || ((burst == BURST_WRAP) && !(WRAP_EN && w_len_ok));
   endfunction

   // WRAP keeps the upper word bits and rolls the low len bits inside the aligned block
   function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [1:0] burst, input logic [7:0] len);
      logic [WW-1:0] w_word;
      logic [WW-1:0] w_mask;
      w_word = addr[ADDR_W-1:OFF_W];
      w_mask = WW'(len);
      case (burst)
         BURST_INCR: w_word = w_word + WW'(1);
         BURST_WRAP: w_word = (w_word & ~w_mask) | ((w_word + WW'(1)) & w_mask);
         default:    ;
      endcase
      f_next_addr = {w_word, addr[OFF_W-1:0]};
   endfunction

   wstate_t           r_wstate, w_wstate_nxt;
   logic              r_awready, r_wready, r_bvalid;
   logic              w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
   logic [1:0]        r_bresp;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wlen, r_wcnt;
   logic [1:0]        r_wburst;
   logic              r_wover, r_werr, r_wunsup;
   logic              w_aw_hs, w_w_hs, w_wlast_idx, w_woor, w_wbeat_en, w_wbeat_err;
   logic [IDX_W-1:0]  w_widx;

   assign w_aw_hs     = r_awready && s_axi.awvalid;
   assign w_w_hs      = r_wready && s_axi.wvalid;
   assign w_wlast_idx = (r_wcnt == r_wlen);
   assign w_woor      = |r_waddr[ADDR_W-1:OFF_W+IDX_W];
   assign w_widx      = r_waddr[OFF_W +: IDX_W];
   assign w_wbeat_en  = aresetn && w_w_hs && !r_wover && !r_wunsup && !w_woor;
   assign w_wbeat_err = r_wover || r_wunsup || w_woor || (s_axi.wlast != w_wlast_idx);

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
         W_DATA:  if (w_w_hs && s_axi.wlast) w_wstate_nxt = W_RESP;
         W_RESP:  if (r_bvalid && s_axi.bready) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
      w_awready_nxt = (w_wstate_nxt == W_IDLE);
      w_wready_nxt  = (w_wstate_nxt == W_DATA);
      w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_waddr   <= '0;
         r_wlen    <= '0;
         r_wburst  <= '0;
         r_wcnt    <= '0;
         r_wover   <= 1'b0;
         r_werr    <= 1'b0;
         r_wunsup  <= 1'b0;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_awready <= w_awready_nxt;
         r_wready  <= w_wready_nxt;
         r_bvalid  <= w_bvalid_nxt;
         if (w_aw_hs) begin
            r_waddr  <= s_axi.awaddr;
            r_wlen   <= s_axi.awlen;
            r_wburst <= s_axi.awburst;
            r_wcnt   <= '0;
            r_wover  <= 1'b0;
            r_werr   <= 1'b0;
            r_wunsup <= f_unsup(s_axi.awburst, s_axi.awlen);
         end
         if (w_w_hs) begin
            r_waddr <= f_next_addr(r_waddr, r_wburst, r_wlen);
            r_werr  <= r_werr || w_wbeat_err;
            if (!w_wlast_idx) r_wcnt <= r_wcnt + 8'd1;
            // counter parks at len; beats past it are dropped until wlast shows up
            if (w_wlast_idx && !s_axi.wlast) r_wover <= 1'b1;
            if (s_axi.wlast) r_bresp <= (r_werr || w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (w_wbeat_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (s_axi.wstrb[b]) r_mem[w_widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
         end
      end
   end

   rstate_t           r_rstate, w_rstate_nxt;
   logic              r_arready, w_arready_nxt;
   logic [ADDR_W-1:0] r_raddr;
   logic [7:0]        r_rlen, r_rcnt;
   logic [1:0]        r_rburst;
   logic              r_rdone, r_runsup;
   logic              r_rvalid, r_rlast, r_sk_valid, r_sk_last;
   logic [DATA_W-1:0] r_rdata, r_sk_data;
   logic [1:0]        r_rresp, r_sk_resp;
   logic              w_ar_hs, w_r_hs, w_issue, w_rbad, w_rlast_idx;
   logic [DATA_W-1:0] w_rd_data;

   assign w_ar_hs     = r_arready && s_axi.arvalid;
   assign w_r_hs      = r_rvalid && s_axi.rready;
   // a new read is only issued when the skid entry can absorb it if the output stalls
   assign w_issue     = (r_rstate == R_DATA) && !r_rdone && !r_sk_valid;
   assign w_rbad      = r_runsup || (|r_raddr[ADDR_W-1:OFF_W+IDX_W]);
   assign w_rlast_idx = (r_rcnt == r_rlen);
   assign w_rd_data   = w_rbad ? '0 : r_mem[r_raddr[OFF_W +: IDX_W]];

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
         R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
      w_arready_nxt = (w_rstate_nxt == R_IDLE);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_rstate   <= R_IDLE;
         r_arready  <= 1'b0;
         r_raddr    <= '0;
         r_rlen     <= '0;
         r_rburst   <= '0;
         r_rcnt     <= '0;
         r_rdone    <= 1'b1;
         r_runsup   <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_rresp    <= RESP_OKAY;
         r_rlast    <= 1'b0;
         r_sk_valid <= 1'b0;
         r_sk_data  <= '0;
         r_sk_resp  <= RESP_OKAY;
         r_sk_last  <= 1'b0;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_arready <= w_arready_nxt;
         if (w_ar_hs) begin
            r_raddr  <= s_axi.araddr;
            r_rlen   <= s_axi.arlen;
            r_rburst <= s_axi.arburst;
            r_rcnt   <= '0;
            r_rdone  <= 1'b0;
            r_runsup <= f_unsup(s_axi.arburst, s_axi.arlen);
         end
         if (w_issue) begin
            r_raddr <= f_next_addr(r_raddr, r_rburst, r_rlen);
            r_rcnt  <= r_rcnt + 8'd1;
            if (w_rlast_idx) r_rdone <= 1'b1;
         end
         if (!r_rvalid || s_axi.rready) begin
            if (r_sk_valid) begin
               r_rdata    <= r_sk_data;
               r_rresp    <= r_sk_resp;
               r_rlast    <= r_sk_last;
               r_rvalid   <= 1'b1;
               r_sk_valid <= 1'b0;
            end else if (w_issue) begin
               r_rdata  <= w_rd_data;
               r_rresp  <= w_rbad ? RESP_SLVERR : RESP_OKAY;
               r_rlast  <= w_rlast_idx;
               r_rvalid <= 1'b1;
            end else begin
               r_rvalid <= 1'b0;
            end
         end else if (w_issue) begin
            r_sk_data  <= w_rd_data;
            r_sk_resp  <= w_rbad ? RESP_SLVERR : RESP_OKAY;
            r_sk_last  <= w_rlast_idx;
            r_sk_valid <= 1'b1;
         end
      end
   end

   assign s_axi.awready = r_awready;
   assign s_axi.wready  = r_wready;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign s_axi.rlast   = r_rlast;
endmodule

// File: tb/tb_axi4_mem_slv_responder.sv
// tb/tb_axi4_mem_slv_responder.sv - scoreboard bench for the AXI4 memory responder
module tb_axi4_mem_slv_responder;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 256;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] FIXED  = 2'b00;
   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] WRAP   = 2'b10;
   localparam logic [1:0] RSVD   = 2'b11;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   logic   aclk = 1'b0;
   logic   aresetn = 1'b0;
   int     n_checks = 0;
   int     n_fail = 0;
   int     cyc = 0;
   logic [1:0] q_b[$];
   rbeat_t q_r[$];
   bit     lat_pend = 1'b0;
   int     lat_exp = 0;
   bit     rr_toggle = 1'b0;

   axi4_mem_slv_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s_axi ();

   axi4_mem_slv_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_axi   (s_axi)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   bit     stalled = 1'b0;
   rbeat_t held;
   always @(negedge aclk) begin
      rbeat_t got;
      rbeat_t e;
      got = {s_axi.rdata, s_axi.rresp, s_axi.rlast};
      if (stalled) chk("r_hold", {s_axi.rvalid, got}, {1'b1, held});
      if (lat_pend && s_axi.rvalid) begin
         chk("r_latency", cyc, lat_exp);
         lat_pend = 1'b0;
      end
      if (s_axi.rvalid && s_axi.rready) begin
         if (q_r.size() == 0) chk("r_unexpected", 1, 0);
         else begin
            e = q_r.pop_front();
            chk("r_beat", got, e);
         end
         stalled = 1'b0;
      end else if (s_axi.rvalid) begin
         stalled = 1'b1;
         held = got;
      end else begin
         stalled = 1'b0;
      end
      if (s_axi.bvalid && s_axi.bready) begin
         if (q_b.size() == 0) chk("b_unexpected", 1, 0);
         else chk("bresp", s_axi.bresp, q_b.pop_front());
      end
   end

   initial begin
      int ph = 0;
      forever begin
         @(posedge aclk); #1;
         if (rr_toggle) begin
            s_axi.rready = (ph == 0);
            ph = (ph + 1) % 3;
         end else begin
            s_axi.rready = 1'b1;
            ph = 0;
         end
      end
   end

   task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      s_axi.awaddr = addr; s_axi.awlen = len; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
      while (!s_axi.awready && n < 50) begin @(posedge aclk); #1; n++; end
      chk("aw_handshake", n < 50, 1);
      @(posedge aclk); #1;
      s_axi.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wlast = last; s_axi.wvalid = 1'b1;
      while (!s_axi.wready && n < 50) begin @(posedge aclk); #1; n++; end
      chk("w_handshake", n < 50, 1);
      @(posedge aclk); #1;
      s_axi.wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      s_axi.araddr = addr; s_axi.arlen = len; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
      while (!s_axi.arready && n < 50) begin @(posedge aclk); #1; n++; end
      chk("ar_handshake", n < 50, 1);
      lat_exp  = cyc + 2;
      lat_pend = 1'b1;
      @(posedge aclk); #1;
      s_axi.arvalid = 1'b0;
   endtask

   task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
      q_r.push_back({data, resp, last});
   endtask

   task automatic drain();
      int n = 0;
      while ((q_b.size() != 0 || q_r.size() != 0) && n < 300) begin @(posedge aclk); #1; n++; end
      chk("drain", n < 300, 1);
      @(posedge aclk); #1;
   endtask

   task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] burst, input logic [1:0] resp);
      q_b.push_back(resp);
      send_aw(addr, 8'd0, burst);
      send_w(data, strb, 1'b1);
      drain();
   endtask

   initial begin
      s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awburst = '0; s_axi.awvalid = 1'b0;
      s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
      s_axi.bready = 1'b1;
      s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arburst = '0; s_axi.arvalid = 1'b0;
      s_axi.rready = 1'b1;

      repeat (3) @(posedge aclk);
      #1;
      chk("rst_outputs", {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready,
                          s_axi.rvalid, s_axi.rlast, s_axi.bresp, s_axi.rresp}, 0);
      aresetn = 1'b1;
      chk("rst_ready_low_at_release", {s_axi.awready, s_axi.arready}, 2'b00);
      @(posedge aclk); #1;
      chk("rst_ready_after_release", {s_axi.awready, s_axi.arready}, 2'b11);

      // INCR write then read back with latency check
      q_b.push_back(OKAY);
      send_aw(32'h10, 8'd3, INCR);
      for (int i = 0; i < 4; i++) send_w(32'hA0 + i, 4'hF, i == 3);
      drain();
      for (int i = 0; i < 4; i++) push_r(32'hA0 + i, OKAY, i == 3);
      send_ar(32'h10, 8'd3, INCR);
      drain();

      // partial strobes
      wr1(32'h40, 32'hFFFF_FFFF, 4'hF, INCR, OKAY);
      wr1(32'h40, 32'h1234_5678, 4'h3, INCR, OKAY);
      push_r(32'hFFFF_5678, OKAY, 1'b1);
      send_ar(32'h40, 8'd0, INCR);
      drain();

      // out of range write aliases word 0 if not suppressed
      wr1(32'h0, 32'hC0C0_C0C0, 4'hF, INCR, OKAY);
      wr1(32'h400, 32'h5A5A_5A5A, 4'hF, INCR, SLVERR);
      push_r(32'h0, SLVERR, 1'b0);
      push_r(32'h0, SLVERR, 1'b1);
      send_ar(32'h400, 8'd1, INCR);
      drain();
      push_r(32'hC0C0_C0C0, OKAY, 1'b1);
      send_ar(32'h0, 8'd0, INCR);
      drain();

      // top word then crossing the end of memory
      wr1(32'h3FC, 32'hDEAD_BEEF, 4'hF, INCR, OKAY);
      push_r(32'hDEAD_BEEF, OKAY, 1'b0);
      push_r(32'h0, SLVERR, 1'b1);
      send_ar(32'h3FC, 8'd1, INCR);
      drain();

      // 8-beat read under rready stalls
      q_b.push_back(OKAY);
      send_aw(32'h80, 8'd7, INCR);
      for (int i = 0; i < 8; i++) send_w(32'hB0 + i, 4'hF, i == 7);
      drain();
      for (int i = 0; i < 8; i++) push_r(32'hB0 + i, OKAY, i == 7);
      rr_toggle = 1'b1;
      send_ar(32'h80, 8'd7, INCR);
      drain();
      rr_toggle = 1'b0;

      // early wlast, then a clean burst
      q_b.push_back(SLVERR);
      send_aw(32'h100, 8'd3, INCR);
      send_w(32'h11, 4'hF, 1'b0);
      send_w(32'h22, 4'hF, 1'b1);
      drain();
      q_b.push_back(OKAY);
      send_aw(32'h100, 8'd1, INCR);
      send_w(32'h33, 4'hF, 1'b0);
      send_w(32'h44, 4'hF, 1'b1);
      drain();
      push_r(32'h33, OKAY, 1'b0);
      push_r(32'h44, OKAY, 1'b1);
      send_ar(32'h100, 8'd1, INCR);
      drain();

      // FIXED burst: last beat wins, reads repeat the same word
      q_b.push_back(OKAY);
      send_aw(32'h200, 8'd2, FIXED);
      for (int i = 1; i <= 3; i++) send_w(i, 4'hF, i == 3);
      drain();
      push_r(32'h3, OKAY, 1'b0);
      push_r(32'h3, OKAY, 1'b1);
      send_ar(32'h200, 8'd1, FIXED);
      drain();

      // reserved burst type
      wr1(32'h10, 32'h5555_5555, 4'hF, RSVD, SLVERR);
      push_r(32'h0, SLVERR, 1'b1);
      send_ar(32'h10, 8'd0, RSVD);
      drain();

      // illegal WRAP length
      q_b.push_back(SLVERR);
      send_aw(32'h20, 8'd2, WRAP);
      for (int i = 0; i < 3; i++) send_w(32'h77, 4'hF, i == 2);
      drain();

      // WRAP from 0x18 over words 0x10..0x1C
`ifdef AXI_SLV_WRAP_EN
      q_b.push_back(OKAY);
`else
      q_b.push_back(SLVERR);
`endif
      send_aw(32'h18, 8'd3, WRAP);
      for (int i = 1; i <= 4; i++) send_w(i, 4'hF, i == 4);
      drain();
`ifdef AXI_SLV_WRAP_EN
      push_r(32'h3, OKAY, 1'b0);
      push_r(32'h4, OKAY, 1'b0);
      push_r(32'h1, OKAY, 1'b0);
      push_r(32'h2, OKAY, 1'b1);
`else
      for (int i = 0; i < 4; i++) push_r(32'hA0 + i, OKAY, i == 3);
`endif
      send_ar(32'h10, 8'd3, INCR);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
